di_reg_terminal: RTL and testbench

- Register terminal downstream of the host interface's device-interface port.
- Decodes the endpoint/register address, holds a bank of 16-bit read/write control registers, and exposes read-only status slots.
- Answers reads with a fixed-latency rdwr_ready handshake.
- Outputs from several terminals with distinct TERM_ADDR are OR-combined before returning to the host interface: when not selected, a terminal drives zero data and no ready.

---
 rtl/di_reg_terminal.sv | 139 +++++++++++++
 tb/tb_di_reg_terminal.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/di_reg_terminal.sv
// di_reg_terminal: register terminal behind the host device-interface port.
// Holds a bank of 16-bit R/W control registers plus read-only status slots,
// answers reads with a fixed-latency rdwr_ready pulse, and drives zero data
// when not addressed so several terminals can be OR-combined.
//
// state  | meaning
// S_IDLE | no read outstanding, accepting a new diRead
// S_WAIT | read captured, counting down the remaining latency
// S_DONE | rdwr_ready high for one cycle, data presented
module di_reg_terminal #(
  parameter logic [15:0]            TERM_ADDR    = 16'h0000,
  parameter int                     NUM_REGS     = 8,
  parameter logic [15:0]            RO_MASK      = 16'h0000,
  parameter logic [NUM_REGS*16-1:0] RESET_VALUES = '0,
  parameter int                     READ_LATENCY = 2
) (
  input  logic                     if_clock,
  input  logic                     reset,
  input  logic [15:0]              diEpAddr,
  input  logic [15:0]              diRegAddr,
  input  logic [15:0]              diRegDataIn,
  input  logic                     diWrite,
  input  logic                     diRead,
  input  logic                     diReset,
  output logic [15:0]              diRegDataOut,
  output logic                     rdwr_ready,
  input  logic [NUM_REGS*16-1:0]   status_in,
  output logic [NUM_REGS*16-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      write_strobe,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        hold_q, hold_d;
  logic [15:0]        dout_q, dout_d;
  logic [15:0]        regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] strobe_q;
  logic               sel;
  logic               soft_rst;
  logic [15:0]        rd_val;
  logic [NUM_REGS-1:0] wr_hit;

  assign sel      = (diEpAddr == TERM_ADDR);
  assign soft_rst = diReset && sel;

  // Address decode: read mux (out-of-range falls through to zero) and per-slot write enables.
  always_comb begin
    rd_val = 16'h0000;
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (diRegAddr == 16'(i)) begin
        rd_val    = RO_MASK[i] ? status_in[16*i +: 16] : regs_q[i];
        wr_hit[i] = diWrite && sel && !RO_MASK[i] && !soft_rst;
      end
    end
  end

  // Register bank; hard or soft reset reloads the reset image and beats a same-cycle write.
  always_ff @(posedge if_clock) begin
    if (reset || soft_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUES[16*i +: 16];
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) regs_q[i] <= diRegDataIn;
      end
    end
  end

  // Write strobe is the registered write enable, so it lines up with the new register value.
  always_ff @(posedge if_clock) begin
    if (reset) strobe_q <= '0;
    else       strobe_q <= wr_hit;
  end

  // Read FSM state, latency counter, capture and output data registers.
  always_ff @(posedge if_clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hold_q  <= 16'h0000;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic: the counter is loaded with LATENCY-1 and DONE is entered as it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (diRead && sel) begin
          hold_d = rd_val;
          cnt_d  = 4'(READ_LATENCY - 1);
          if (READ_LATENCY == 1) begin
            state_d = S_DONE;
            dout_d  = rd_val;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          dout_d  = hold_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An unaddressed terminal must not pollute the OR-combined return bus.
    if (!sel) dout_d = 16'h0000;
  end

  // Status view of the bank; read-only slots carry no storage value.
  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_out[16*i +: 16] = RO_MASK[i] ? 16'h0000 : regs_q[i];
    end
  end

  assign diRegDataOut = dout_q;
  assign rdwr_ready   = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign write_strobe = strobe_q;

endmodule

// File: tb/tb_di_reg_terminal.sv
// Self-checking bench for di_reg_terminal: directed steps from the test plan
// followed by randomized accesses checked against a slot-array model.
module tb_di_reg_terminal;

  localparam logic [15:0]  TERM = 16'h0010;
  localparam logic [15:0]  RO   = 16'h0004;
  localparam logic [127:0] RV   = {16'h7007, 16'h6006, 16'h5005, 16'h4004,
                                   16'h3003, 16'h2002, 16'h1001, 16'h1234};

  logic         if_clock = 1'b0;
  logic         reset;
  logic [15:0]  diEpAddr, diRegAddr, diRegDataIn;
  logic         diWrite, diRead, diReset;
  logic [15:0]  diRegDataOut;
  logic         rdwr_ready;
  logic [127:0] status_in;
  logic [127:0] regs_out;
  logic [7:0]   write_strobe;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] rv_tab [8] = '{16'h1234, 16'h1001, 16'h2002, 16'h3003,
                              16'h4004, 16'h5005, 16'h6006, 16'h7007};
  logic [15:0] model [8];
  logic [15:0] last_dout;

  di_reg_terminal #(
    .TERM_ADDR(TERM), .NUM_REGS(8), .RO_MASK(RO),
    .RESET_VALUES(RV), .READ_LATENCY(2)
  ) dut (
    .if_clock(if_clock), .reset(reset), .diEpAddr(diEpAddr), .diRegAddr(diRegAddr),
    .diRegDataIn(diRegDataIn), .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .diRegDataOut(diRegDataOut), .rdwr_ready(rdwr_ready), .status_in(status_in),
    .regs_out(regs_out), .write_strobe(write_strobe), .busy(busy)
  );

  always #5 if_clock = ~if_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge if_clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = rv_tab[i];
  endtask

  function automatic logic [127:0] exp_regs();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = RO[i] ? 16'h0000 : model[i];
    return r;
  endfunction

  // One host access: optional read and/or write in the same cycle, then
  // follow the read through to its ready pulse.
  task automatic access(input logic [15:0] ep, input logic [15:0] addr,
                        input bit rd, input bit wr, input logic [15:0] data);
    bit          sel, inr, ro, wr_ok;
    logic [15:0] exp_rd;
    logic [7:0]  exp_strobe;
    sel    = (ep == TERM);
    inr    = (addr < 16'd8);
    ro     = inr && RO[addr[3:0]];
    wr_ok  = wr && sel && inr && !ro;
    exp_rd = 16'h0000;
    if (sel && inr) exp_rd = ro ? status_in[addr[2:0]*16 +: 16] : model[addr[2:0]];
    exp_strobe = 8'h00;
    if (wr_ok) exp_strobe[addr[2:0]] = 1'b1;

    diEpAddr = ep; diRegAddr = addr; diRegDataIn = data;
    diRead = rd; diWrite = wr;
    step();
    diRead = 1'b0; diWrite = 1'b0;
    if (wr_ok) model[addr[2:0]] = data;
    if (!sel) last_dout = 16'h0000;
    chk("strobe", 128'(write_strobe), 128'(exp_strobe));
    chk("regs_out", regs_out, exp_regs());
    chk("dout_hold", 128'(diRegDataOut), 128'(last_dout));
    if (rd) begin
      chk("busy_n1", 128'(busy), 128'(sel));
      chk("ready_n1", 128'(rdwr_ready), 128'(0));
      step();
      chk("ready_n2", 128'(rdwr_ready), 128'(sel));
      chk("busy_n2", 128'(busy), 128'(sel));
      chk("rdata", 128'(diRegDataOut), 128'(exp_rd));
      chk("strobe_clr", 128'(write_strobe), 128'(0));
      if (sel) last_dout = exp_rd;
      step();
      chk("ready_n3", 128'(rdwr_ready), 128'(0));
      chk("busy_n3", 128'(busy), 128'(0));
      chk("dout_after", 128'(diRegDataOut), 128'(last_dout));
    end
  endtask

  initial begin
    reset = 1'b1; diEpAddr = TERM; diRegAddr = 16'h0; diRegDataIn = 16'h0;
    diWrite = 1'b0; diRead = 1'b0; diReset = 1'b0;
    status_in = {$urandom, $urandom, $urandom, $urandom};
    status_in[2*16 +: 16] = 16'hA5A5;
    model_reset();
    last_dout = 16'h0000;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_regs", regs_out, exp_regs());
    chk("rst_ready", 128'(rdwr_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_dout", 128'(diRegDataOut), 128'(0));
    chk("rst_strobe", 128'(write_strobe), 128'(0));

    // directed plan
    access(TERM, 16'd0, 1, 0, 16'h0000);
    access(TERM, 16'd3, 0, 1, 16'hBEEF);
    access(TERM, 16'd3, 1, 0, 16'h0000);
    access(TERM, 16'd2, 0, 1, 16'h1111);
    access(TERM, 16'd2, 1, 0, 16'h0000);
    access(TERM + 16'd1, 16'd1, 1, 1, 16'h5555);
    access(TERM, 16'd4, 0, 1, 16'h1111);
    access(TERM, 16'd4, 1, 1, 16'h0F0F);
    access(TERM, 16'd4, 1, 0, 16'h0000);
    access(TERM, 16'd20, 1, 0, 16'h0000);

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      logic [15:0] ep;
      status_in = {$urandom, $urandom, $urandom, $urandom};
      ep = ($urandom_range(0, 4) == 0) ? TERM + 16'd1 : TERM;
      access(ep, 16'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 16'($urandom));
    end

    // hard reset one cycle after a read: the read must never complete
    diEpAddr = TERM;
    access(TERM, 16'd3, 0, 1, 16'hCAFE);
    diRegAddr = 16'd3; diRead = 1'b1;
    step();
    diRead = 1'b0;
    chk("abort_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    last_dout = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      chk("abort_ready", 128'(rdwr_ready), 128'(0));
      step();
    end
    chk("abort_regs", regs_out, exp_regs());
    chk("abort_busy_clr", 128'(busy), 128'(0));

    // soft reset: unselected is ignored, selected reloads, beats a same-cycle write
    access(TERM, 16'd5, 0, 1, 16'h9999);
    access(TERM, 16'd6, 0, 1, 16'h8888);
    diEpAddr = TERM + 16'd1; diReset = 1'b1;
    step();
    diReset = 1'b0;
    chk("sreset_unsel", regs_out, exp_regs());
    diEpAddr = TERM; diReset = 1'b1; diWrite = 1'b1; diRegAddr = 16'd5; diRegDataIn = 16'h4242;
    step();
    diReset = 1'b0; diWrite = 1'b0;
    model_reset();
    chk("sreset_regs", regs_out, exp_regs());
    chk("sreset_strobe", 128'(write_strobe), 128'(0));

    // soft reset during an in-flight read leaves the read intact
    access(TERM, 16'd3, 0, 1, 16'hCAFE);
    diRegAddr = 16'd3; diRead = 1'b1;
    step();
    diRead = 1'b0; diReset = 1'b1;
    step();
    diReset = 1'b0;
    model_reset();
    chk("sr_rd_ready", 128'(rdwr_ready), 128'(1));
    chk("sr_rd_data", 128'(diRegDataOut), 128'(16'hCAFE));
    chk("sr_rd_regs", regs_out, exp_regs());
    step();
    chk("sr_rd_done", 128'(rdwr_ready), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
